// File: rtl/icache_line_responder.sv
// icache_line_responder: serves ICache line-fill requests from a synchronous
// instruction RAM. Requests are queued, numbered with a wrapping serial,
// fetched one word per cycle and returned as a single-cycle result pulse.
module icache_line_responder #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned LINE_WORDS    = 4,
  parameter int unsigned EXTRA_LATENCY = 0,
  parameter int unsigned QUEUE_DEPTH   = 2,
  parameter int unsigned SERIAL_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             reqValid,
  input  logic [ADDR_WIDTH-1:0]            reqAddr,
  output logic                             reqReady,
  output logic [SERIAL_WIDTH-1:0]          reqSerial,
  output logic                             ramRE,
  output logic [ADDR_WIDTH-3:0]            ramAddr,
  input  logic [WORD_WIDTH-1:0]            ramRData,
  output logic                             resultValid,
  output logic [SERIAL_WIDTH-1:0]          resultSerial,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] resultData
);

  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF    = BEAT_W + 2;
  localparam int unsigned LA_W   = ADDR_WIDTH - OFF;
  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned WCNT_W = (EXTRA_LATENCY > 1) ? $clog2(EXTRA_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    LAST,
    RESP
  } state_t;

  state_t                  state;
  logic [LA_W-1:0]         qAddr   [QUEUE_DEPTH];
  logic [SERIAL_WIDTH-1:0] qSerial [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wrPtr;
  logic [PTR_W-1:0]        rdPtr;
  logic [CNT_W-1:0]        count;
  logic                    push;
  logic                    pop;
  logic [LA_W-1:0]         lineAddr;
  logic [SERIAL_WIDTH-1:0] curSerial;
  logic [BEAT_W-1:0]       beat;
  logic [WCNT_W-1:0]       waitCnt;
  logic                    unusedOffset;

  // Line offset bits of the request address carry no information here.
  assign unusedOffset = ^reqAddr[OFF-1:0];

  // Ready depends only on occupancy, never on a same-cycle pop.
  always_comb begin
    reqReady = (count != CNT_W'(QUEUE_DEPTH));
    push     = reqValid && reqReady;
    pop      = (state == IDLE) && (count != '0);
  end

  // Queue storage: aligned line address plus the serial given at accept.
  always_ff @(posedge clk) begin
    if (push) begin
      qAddr[wrPtr]   <= reqAddr[ADDR_WIDTH-1:OFF];
      qSerial[wrPtr] <= reqSerial;
    end
  end

  // Queue pointers, occupancy and the wrapping serial counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      reqSerial <= '0;
    end else begin
      if (push) begin
        wrPtr     <= (wrPtr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
        reqSerial <= reqSerial + SERIAL_WIDTH'(1);
      end
      if (pop) begin
        rdPtr <= (rdPtr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Line fetch FSM: pop, optional wait, word-by-word read, capture, respond.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      lineAddr     <= '0;
      curSerial    <= '0;
      beat         <= '0;
      waitCnt      <= '0;
      ramRE        <= 1'b0;
      ramAddr      <= '0;
      resultValid  <= 1'b0;
      resultSerial <= '0;
      resultData   <= '0;
    end else begin
      resultValid <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            lineAddr  <= qAddr[rdPtr];
            curSerial <= qSerial[rdPtr];
            if (EXTRA_LATENCY > 0) begin
              state   <= WAIT;
              waitCnt <= WCNT_W'(EXTRA_LATENCY - 1);
            end else begin
              state   <= READ;
              beat    <= '0;
              ramRE   <= 1'b1;
              ramAddr <= {qAddr[rdPtr], BEAT_W'(0)};
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state   <= READ;
            beat    <= '0;
            ramRE   <= 1'b1;
            ramAddr <= {lineAddr, BEAT_W'(0)};
          end else begin
            waitCnt <= waitCnt - WCNT_W'(1);
          end
        end
        READ: begin
          // Data on ramRData belongs to the previous beat's read.
          for (int unsigned i = 0; i < LINE_WORDS - 1; i++) begin
            if (beat == BEAT_W'(i + 1)) begin
              resultData[i*WORD_WIDTH +: WORD_WIDTH] <= ramRData;
            end
          end
          if (beat == BEAT_W'(LINE_WORDS - 1)) begin
            state <= LAST;
            ramRE <= 1'b0;
          end else begin
            beat    <= beat + BEAT_W'(1);
            ramAddr <= {lineAddr, beat + BEAT_W'(1)};
          end
        end
        LAST: begin
          resultData[(LINE_WORDS-1)*WORD_WIDTH +: WORD_WIDTH] <= ramRData;
          resultSerial <= curSerial;
          resultValid  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_line_responder.sv
// Bench for icache_line_responder: directed requests feed a scoreboard of
// expected results and RAM read sequences; a negedge monitor compares them.
module tb_icache_line_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         reqValid0, reqValid1;
  logic [31:0]  reqAddr0, reqAddr1;
  logic         reqReady0, reqReady1;
  logic [3:0]   reqSerial0, reqSerial1;
  logic         ramRE0, ramRE1;
  logic [29:0]  ramAddr0, ramAddr1;
  logic [31:0]  ramRData0, ramRData1;
  logic         resultValid0, resultValid1;
  logic [3:0]   resultSerial0, resultSerial1;
  logic [127:0] resultData0, resultData1;

  icache_line_responder #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(4),
    .EXTRA_LATENCY(0), .QUEUE_DEPTH(2), .SERIAL_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid0), .reqAddr(reqAddr0),
    .reqReady(reqReady0), .reqSerial(reqSerial0), .ramRE(ramRE0),
    .ramAddr(ramAddr0), .ramRData(ramRData0), .resultValid(resultValid0),
    .resultSerial(resultSerial0), .resultData(resultData0)
  );

  icache_line_responder #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(4),
    .EXTRA_LATENCY(3), .QUEUE_DEPTH(2), .SERIAL_WIDTH(4)
  ) dutL (
    .clk(clk), .rst(rst), .reqValid(reqValid1), .reqAddr(reqAddr1),
    .reqReady(reqReady1), .reqSerial(reqSerial1), .ramRE(ramRE1),
    .ramAddr(ramAddr1), .ramRData(ramRData1), .resultValid(resultValid1),
    .resultSerial(resultSerial1), .resultData(resultData1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [29:0] a);
    case (a)
      30'h1000: memWord = 32'hea000000;
      30'h1001: memWord = 32'heafffffe;
      30'h1002: memWord = 32'he3a00000;
      30'h1003: memWord = 32'he3a01000;
      default:  memWord = {a[15:0], ~a[15:0]} ^ 32'h13579bdf;
    endcase
  endfunction

  function automatic logic [127:0] lineOf(input logic [31:0] a);
    logic [29:0] b;
    logic [127:0] r;
    b = {a[31:4], 2'b00};
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = memWord(b | 30'(i));
    return r;
  endfunction

  // Synchronous backing RAMs: data appears the cycle after ramRE.
  always @(posedge clk) begin
    if (ramRE0) ramRData0 <= memWord(ramAddr0);
    if (ramRE1) ramRData1 <= memWord(ramAddr1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   ser;
    logic [127:0] line;
    int           resCyc;
    logic [29:0]  base;
    int           rdCyc;
  } exp_t;

  exp_t resQ0[$];
  exp_t resQ1[$];
  exp_t ramQ0[$];
  exp_t ramQ1[$];
  exp_t me;
  int   beat0 = 0;
  int   beat1 = 0;

  // Monitor: every result pulse and every RAM read is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      resQ0.delete(); resQ1.delete(); ramQ0.delete(); ramQ1.delete();
      beat0 = 0; beat1 = 0;
    end else begin
      if (resultValid0) begin
        checks++;
        if (resQ0.size() == 0) begin
          errors++;
          $display("FAIL spurious resultValid dut: serial %0h", resultSerial0);
        end else begin
          checks--;
          me = resQ0.pop_front();
          check("resultSerial dut", 128'(resultSerial0), 128'(me.ser));
          check("resultData dut", resultData0, me.line);
          check("resultCycle dut", 128'(cyc), 128'(me.resCyc));
        end
      end
      if (resultValid1) begin
        checks++;
        if (resQ1.size() == 0) begin
          errors++;
          $display("FAIL spurious resultValid dutL: serial %0h", resultSerial1);
        end else begin
          checks--;
          me = resQ1.pop_front();
          check("resultSerial dutL", 128'(resultSerial1), 128'(me.ser));
          check("resultData dutL", resultData1, me.line);
          check("resultCycle dutL", 128'(cyc), 128'(me.resCyc));
        end
      end
      if (ramRE0) begin
        checks++;
        if (ramQ0.size() == 0) begin
          errors++;
          $display("FAIL spurious ramRE dut: addr %0h", ramAddr0);
        end else begin
          checks--;
          me = ramQ0[0];
          check("ramAddr dut", 128'(ramAddr0), 128'(me.base | 30'(beat0)));
          check("ramCycle dut", 128'(cyc), 128'(me.rdCyc + beat0));
          beat0++;
          if (beat0 == 4) begin
            void'(ramQ0.pop_front());
            beat0 = 0;
          end
        end
      end
      if (ramRE1) begin
        checks++;
        if (ramQ1.size() == 0) begin
          errors++;
          $display("FAIL spurious ramRE dutL: addr %0h", ramAddr1);
        end else begin
          checks--;
          me = ramQ1[0];
          check("ramAddr dutL", 128'(ramAddr1), 128'(me.base | 30'(beat1)));
          check("ramCycle dutL", 128'(cyc), 128'(me.rdCyc + beat1));
          beat1++;
          if (beat1 == 4) begin
            void'(ramQ1.pop_front());
            beat1 = 0;
          end
        end
      end
    end
  end

  logic [3:0] expSer [2];
  int         prevRes [2];

  // Present one request, wait (bounded) for acceptance, push expectations.
  task automatic sendReq(input int k, input logic [31:0] a, input logic [127:0] line,
                         output int accCyc);
    int n;
    int p;
    int lat;
    exp_t e;
    lat = (k == 0) ? 0 : 3;
    if (k == 0) begin reqValid0 = 1'b1; reqAddr0 = a; end
    else        begin reqValid1 = 1'b1; reqAddr1 = a; end
    n = 0;
    accCyc = -1;
    while (accCyc < 0 && n < 100) begin
      @(negedge clk);
      if ((k == 0) ? reqReady0 : reqReady1) begin
        accCyc = cyc;
        check("reqSerial", 128'((k == 0) ? reqSerial0 : reqSerial1), 128'(expSer[k]));
        p = (cyc + 1 > prevRes[k] + 1) ? cyc + 1 : prevRes[k] + 1;
        e.ser    = expSer[k];
        e.line   = line;
        e.resCyc = p + 2 + lat + 4;
        e.base   = {a[31:4], 2'b00};
        e.rdCyc  = p + 1 + lat;
        prevRes[k] = e.resCyc;
        expSer[k]  = expSer[k] + 4'd1;
        if (k == 0) begin resQ0.push_back(e); ramQ0.push_back(e); end
        else        begin resQ1.push_back(e); ramQ1.push_back(e); end
      end
      n++;
    end
    if (accCyc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept timeout: addr %0h not accepted, required within 100 cycles", a);
    end
    @(posedge clk);
    #1;
    if (k == 0) reqValid0 = 1'b0;
    else        reqValid1 = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((resQ0.size() > 0 || resQ1.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (resQ0.size() > 0 || resQ1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d results outstanding, required 0",
               resQ0.size() + resQ1.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkReset();
    @(negedge clk);
    check("reset reqReady", 128'(reqReady0), 128'(1'b1));
    check("reset reqSerial", 128'(reqSerial0), 128'(4'd0));
    check("reset ramRE", 128'(ramRE0), 128'(1'b0));
    check("reset ramAddr", 128'(ramAddr0), 128'(30'd0));
    check("reset resultValid", 128'(resultValid0), 128'(1'b0));
    check("reset resultSerial", 128'(resultSerial0), 128'(4'd0));
    check("reset resultData", resultData0, 128'd0);
    check("reset dutL ramRE", 128'(ramRE1), 128'(1'b0));
    check("reset dutL resultValid", 128'(resultValid1), 128'(1'b0));
  endtask

  localparam logic [127:0] LINE4000 = 128'he3a01000_e3a00000_eafffffe_ea000000;

  initial begin
    int a1, a2, a3, a4, acc;
    rst = 1'b0;
    reqValid0 = 1'b0; reqAddr0 = '0;
    reqValid1 = 1'b0; reqAddr1 = '0;
    expSer[0] = '0; expSer[1] = '0;
    prevRes[0] = -1000; prevRes[1] = -1000;

    // A request held during reset must not be accepted.
    repeat (2) @(posedge clk);
    #1;
    reqValid0 = 1'b1; reqAddr0 = 32'h0000_4000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    reqValid0 = 1'b0;
    checkReset();
    repeat (3) @(posedge clk);
    #1;

    // Single fill and unaligned address of the same line.
    sendReq(0, 32'h0000_4000, LINE4000, acc);
    waitDrain();
    sendReq(0, 32'h0000_4004, LINE4000, acc);
    waitDrain();

    // Four back-to-back requests: the fourth stalls until the queue drains one.
    sendReq(0, 32'h0000_4000, lineOf(32'h0000_4000), a1);
    sendReq(0, 32'h0000_4040, lineOf(32'h0000_4040), a2);
    sendReq(0, 32'h0000_4100, lineOf(32'h0000_4100), a3);
    sendReq(0, 32'h0000_4200, lineOf(32'h0000_4200), a4);
    check("second accept cycle", 128'(a2), 128'(a1 + 1));
    check("third accept cycle", 128'(a3), 128'(a1 + 2));
    check("stalled accept cycle", 128'(a4), 128'(a1 + 9));
    waitDrain();

    // Extra latency instance: reads start at C+5, result at C+10.
    sendReq(1, 32'h0000_4000, LINE4000, acc);
    waitDrain();

    // Reset during the third READ cycle discards the in-flight line.
    sendReq(0, 32'h0000_8000, lineOf(32'h0000_8000), acc);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    expSer[0] = '0;
    prevRes[0] = -1000;
    checkReset();
    repeat (12) @(posedge clk);
    #1;

    // Seventeen fills: serials 0..15 then wrap to 0.
    for (int i = 0; i < 17; i++) begin
      sendReq(0, 32'h0001_0000 + 32'(i) * 32'h10, lineOf(32'h0001_0000 + 32'(i) * 32'h10), acc);
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
